hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

- Pipeline hazard controller for the 5-stage RV32 core.
- Owns sequencing of the IF/ID, ID/EX, EX/MEM and MEM/WB registers:
  - generates EX-stage operand forwarding selects;
  - detects load-use hazards;
  - flushes on taken branch/jump;
  - holds the pipeline while a multi-cycle MUL/DIV runs in EX, using a small FSM.
- Also keeps saturating performance counters for stall and flush events.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 32, width of each performance counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  source registers of instruction in ID
- Rs1E, Rs2E, RdE  in  REG_ADDR_WIDTH  sources/destination of instruction in EX
- RegWriteE  in  1  EX instruction writes rd
- ResultSrcE  in  2  EX result select; 2'b01 = load
- RdM, RdW  in  REG_ADDR_WIDTH  destination in MEM / WB
- RegWriteM, RegWriteW  in  1  MEM / WB instruction writes rd
- PCSrcE  in  1  taken branch/jump resolved in EX
- MduOpE  in  1  EX instruction is a multi-cycle MUL/DIV; never asserted together with PCSrcE
- MduDone  in  1  single-cycle pulse from MDU, result valid
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 WB result, 10 MEM ALU result
- StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX
- FlushD, FlushE, FlushM  out  1  clear IF-ID / ID-EX / EX-MEM to bubble
- MduStart  out  1  one-cycle start strobe to MDU
- MduBusy  out  1  FSM in BUSY
- LoadUseCnt, FlushCnt, MduStallCnt  out  CNT_WIDTH  performance counters

## Operation
- **Forwarding**, evaluated for A and B independently:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E/Rs2E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E/Rs2E;
  - else 00.
  - MEM has priority over WB.
- **lwStall** = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- **MDU FSM**, states IDLE and BUSY:
  - IDLE: MduOpE=1 → MduStart=1, next state BUSY.
  - BUSY: MduDone=1 → next state IDLE; otherwise stay.
  - MduDone is ignored in IDLE.
- **mduStall** = MduOpE & ~(BUSY & MduDone).
- **Output equations:**
  - StallE = mduStall
  - FlushM = mduStall
  - StallF = StallD = mduStall | lwStall
  - FlushE = PCSrcE | (lwStall & ~mduStall); never flush a held MDU op
  - FlushD = PCSrcE
- **Counters** are saturating at all-ones; each increments once per cycle:
  - LoadUseCnt: cycles with lwStall & ~mduStall
  - FlushCnt: cycles with PCSrcE
  - MduStallCnt: cycles with mduStall

## Timing
- **Combinational paths:** forwarding, stall and flush outputs depend combinationally on inputs and FSM state.
- **Registered state:** FSM state and counters update on the rising edge of clk.
- **Reset values:**
  - state = IDLE;
  - all counters 0;
  - MduBusy = 0, MduStart = 0;
  - with inputs low, all stall/flush/forward outputs are 0.
- **MDU timing:**
  - Op enters EX at cycle N → MduStart at N; MduBusy from N+1.
  - MduDone at cycle K≥N+1 → stall drops in K; op advances at edge K→K+1; state IDLE at K+1.
  - A back-to-back MDU op arriving in EX at K+1 starts fresh, with MduStart at K+1.
- **Mid-operation reset:** rst_n low during BUSY returns the FSM to IDLE immediately. A late MduDone is ignored.
- **Counter saturation:** a counter at 2^CNT_WIDTH-1 holds its value.

## Configuration
- Macro: `HAZARD_FWD_EN`.
- Defined: forwarding as described in Operation.
- Undefined:
  - ForwardAE/ForwardBE are tied to 00.
  - lwStall is replaced by rawStall = ((RegWriteE & RdE!=0 & RdE∈{Rs1D,Rs2D}) | (RegWriteM & RdM!=0 & RdM∈{Rs1D,Rs2D})).
  - WB hazards are resolved by the register file writing in the first half-cycle.
  - All other equations use rawStall in place of lwStall.

## Test plan
- **MEM forwarding over WB:** RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 → ForwardAE=10, ForwardBE=00. Same with RdM=0 → ForwardAE=01.
- **Load-use:** ResultSrcE=01, RdE=7, Rs2D=7 for 1 cycle → StallF=StallD=FlushE=1 for that cycle; LoadUseCnt 0→1.
- **Taken branch:** PCSrcE=1 for 1 cycle → FlushD=FlushE=1, no stalls; FlushCnt=1.
- **MDU op:** MduOpE=1 at cycle 0, MduDone at cycle 4:
  - MduStart=1 only at cycle 0; MduBusy=1 in cycles 1–4;
  - StallF/D/E and FlushM=1 in cycles 0–3, 0 in cycle 4;
  - MduStallCnt=4.
- **Load-use during MDU hold:** lwStall true while mduStall → FlushE=0, StallE=1; LoadUseCnt unchanged.
- **Reset in BUSY:** assert rst_n=0 at cycle 2 of an MDU op → MduBusy=0 and all counters 0 immediately. After release with MduOpE=1 → new MduStart.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX-stage forwarding, load-use/RAW stall, branch flush, MDU hold FSM and
// saturating event counters. Define HAZARD_FWD_EN to enable operand forwarding.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic                      RegWriteE,
    input  logic [1:0]                ResultSrcE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      PCSrcE,
    input  logic                      MduOpE,
    input  logic                      MduDone,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushM,
    output logic                      MduStart,
    output logic                      MduBusy,
    output logic [CNT_WIDTH-1:0]      LoadUseCnt,
    output logic [CNT_WIDTH-1:0]      FlushCnt,
    output logic [CNT_WIDTH-1:0]      MduStallCnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic                 hz_stall;
    logic                 mdu_stall;
    logic [CNT_WIDTH-1:0] load_use_cnt_q, load_use_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] mdu_stall_cnt_q, mdu_stall_cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic en);
        if (en && (cnt != '1)) return cnt + 1'b1;
        return cnt;
    endfunction

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs,
                                           input logic [REG_ADDR_WIDTH-1:0] rd_m,
                                           input logic                      we_m,
                                           input logic [REG_ADDR_WIDTH-1:0] rd_w,
                                           input logic                      we_w);
        if (we_m && (rd_m != '0) && (rd_m == rs)) return 2'b10;
        if (we_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        hz_stall  = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    end
`else
    // Without forwarding, any pending EX/MEM write to an ID source must wait; WB writes
    // are covered by the first-half-cycle register file write.
    logic unused_fwd;
    assign unused_fwd = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE};

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        hz_stall  = (RegWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D))) ||
                    (RegWriteM && (RdM != '0) && ((RdM == Rs1D) || (RdM == Rs2D)));
    end
`endif

    always_comb begin
        state_d  = state_q;
        MduStart = 1'b0;
        case (state_q)
            IDLE: begin
                if (MduOpE) begin
                    MduStart = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (MduDone) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MduBusy   = (state_q == BUSY);
        mdu_stall = MduOpE && !((state_q == BUSY) && MduDone);
        StallE    = mdu_stall;
        FlushM    = mdu_stall;
        StallF    = mdu_stall | hz_stall;
        StallD    = mdu_stall | hz_stall;
        // A held MDU op stays in ID/EX, so a load-use bubble must not overwrite it.
        FlushE    = PCSrcE | (hz_stall & ~mdu_stall);
        FlushD    = PCSrcE;
    end

    always_comb begin
        load_use_cnt_d  = sat_inc(load_use_cnt_q, hz_stall & ~mdu_stall);
        flush_cnt_d     = sat_inc(flush_cnt_q, PCSrcE);
        mdu_stall_cnt_d = sat_inc(mdu_stall_cnt_q, mdu_stall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            load_use_cnt_q  <= '0;
            flush_cnt_q     <= '0;
            mdu_stall_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            load_use_cnt_q  <= load_use_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
            mdu_stall_cnt_q <= mdu_stall_cnt_d;
        end
    end

    assign LoadUseCnt  = load_use_cnt_q;
    assign FlushCnt    = flush_cnt_q;
    assign MduStallCnt = mdu_stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed MDU/reset/saturation
// sequences and a randomized run against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 8;
    localparam int unsigned MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteE, RegWriteM, RegWriteW, PCSrcE, MduOpE, MduDone;
    logic [1:0]    ResultSrcE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MduStart, MduBusy;
    logic [CW-1:0] LoadUseCnt, FlushCnt, MduStallCnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_busy;
    int unsigned m_lu, m_fl, m_ms;

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MduOpE(MduOpE), .MduDone(MduDone),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MduStart(MduStart), .MduBusy(MduBusy),
        .LoadUseCnt(LoadUseCnt), .FlushCnt(FlushCnt), .MduStallCnt(MduStallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, PCSrcE, MduOpE, MduDone} = '0;
        ResultSrcE = 2'b00;
    endtask

    function automatic int unsigned ref_fwd(input logic [AW-1:0] rs);
`ifdef HAZARD_FWD_EN
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
`endif
        return 0;
    endfunction

    function automatic bit ref_hz();
        bit dep_e, dep_m;
        dep_e = (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
        dep_m = (RdM != 0) && (RdM == Rs1D || RdM == Rs2D);
`ifdef HAZARD_FWD_EN
        return (ResultSrcE == 2'b01) && dep_e;
`else
        return (RegWriteE && dep_e) || (RegWriteM && dep_m);
`endif
    endfunction

    function automatic int unsigned sat(input int unsigned v, input bit en);
        return (en && v < MAXC) ? v + 1 : v;
    endfunction

    // Compare every output against the model mid-cycle, then advance the model on the edge.
    task automatic cycle_check();
        bit hz, md;
        hz = ref_hz();
        md = MduOpE && !(m_busy && MduDone);
        @(negedge clk);
        check("ForwardAE", ForwardAE, ref_fwd(Rs1E));
        check("ForwardBE", ForwardBE, ref_fwd(Rs2E));
        check("StallF", StallF, md || hz);
        check("StallD", StallD, md || hz);
        check("StallE", StallE, md);
        check("FlushM", FlushM, md);
        check("FlushD", FlushD, PCSrcE);
        check("FlushE", FlushE, PCSrcE || (hz && !md));
        check("MduStart", MduStart, !m_busy && MduOpE);
        check("MduBusy", MduBusy, m_busy);
        check("LoadUseCnt", LoadUseCnt, m_lu);
        check("FlushCnt", FlushCnt, m_fl);
        check("MduStallCnt", MduStallCnt, m_ms);
        @(posedge clk);
        m_lu = sat(m_lu, hz && !md);
        m_fl = sat(m_fl, PCSrcE);
        m_ms = sat(m_ms, md);
        m_busy = m_busy ? !MduDone : MduOpE;
        #1;
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_lu = 0;
        m_fl = 0;
        m_ms = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic          regwe;
        logic [1:0]    ressrc;
        logic [AW-1:0] rdm;
        logic          regwm;
        logic [AW-1:0] rdw;
        logic          regww;
        logic          pcsrc;
        logic [1:0]    fa, fb;     // forwarding build
        logic          st_fwd;     // stall, forwarding build
        logic          st_raw;     // stall, no-forwarding build
    } vec_t;

    vec_t vecs[13];

    initial begin
        //            rs1d rs2d rs1e rs2e rde we src rdm wm rdw ww pc fa fb sf sr
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 1'b0, 2'd0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0};
        vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 2'd0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[10] = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[12] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1};

        clear_inputs();
        do_reset();

        // reset state
        #1;
        check("rst_busy", MduBusy, 0);
        check("rst_start", MduStart, 0);
        check("rst_lucnt", LoadUseCnt, 0);
        check("rst_flcnt", FlushCnt, 0);
        check("rst_mscnt", MduStallCnt, 0);
        check("rst_stallf", StallF, 0);
        check("rst_flushe", FlushE, 0);

        // vector table (FSM stays idle)
        for (int i = 0; i < 13; i++) begin
            logic [1:0] efa, efb;
            logic       est;
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d;
            Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e; RdE = vecs[i].rde;
            RegWriteE = vecs[i].regwe; ResultSrcE = vecs[i].ressrc;
            RdM = vecs[i].rdm; RegWriteM = vecs[i].regwm;
            RdW = vecs[i].rdw; RegWriteW = vecs[i].regww;
            PCSrcE = vecs[i].pcsrc;
`ifdef HAZARD_FWD_EN
            efa = vecs[i].fa; efb = vecs[i].fb; est = vecs[i].st_fwd;
`else
            efa = 2'b00; efb = 2'b00; est = vecs[i].st_raw;
`endif
            #1;
            check($sformatf("vec%0d_fa", i), ForwardAE, efa);
            check($sformatf("vec%0d_fb", i), ForwardBE, efb);
            check($sformatf("vec%0d_stallf", i), StallF, est);
            check($sformatf("vec%0d_stalld", i), StallD, est);
            check($sformatf("vec%0d_stalle", i), StallE, 0);
            check($sformatf("vec%0d_flushd", i), FlushD, vecs[i].pcsrc);
            check($sformatf("vec%0d_flushe", i), FlushE, vecs[i].pcsrc | est);
            cycle_check();
        end

        // load-use for one cycle bumps LoadUseCnt 0 -> 1
        clear_inputs();
        do_reset();
        ResultSrcE = 2'b01; RdE = 5'd7; RegWriteE = 1'b1; Rs2D = 5'd7;
        cycle_check();
        clear_inputs();
        check("lu_cnt", LoadUseCnt, 1);

        // taken branch for one cycle
        PCSrcE = 1'b1;
        #1;
        check("br_stallf", StallF, 0);
        check("br_flushd", FlushD, 1);
        check("br_flushe", FlushE, 1);
        cycle_check();
        clear_inputs();
        check("br_cnt", FlushCnt, 1);

        // MDU op: issue cycle 0, done cycle 4, back-to-back op at cycle 5
        do_reset();
        MduOpE = 1'b1;
        for (int c = 0; c < 5; c++) begin
            MduDone = (c == 4);
            #1;
            check($sformatf("mdu_c%0d_start", c), MduStart, c == 0);
            check($sformatf("mdu_c%0d_busy", c), MduBusy, c >= 1);
            check($sformatf("mdu_c%0d_stalle", c), StallE, c < 4);
            check($sformatf("mdu_c%0d_flushm", c), FlushM, c < 4);
            cycle_check();
        end
        MduDone = 1'b0;
        check("mdu_cnt", MduStallCnt, 4);
        #1;
        check("mdu_b2b_start", MduStart, 1);
        check("mdu_b2b_busy", MduBusy, 0);
        cycle_check();

        // load-use while the MDU op is held
        ResultSrcE = 2'b01; RdE = 5'd7; RegWriteE = 1'b1; Rs1D = 5'd7;
        #1;
        check("lumdu_flushe", FlushE, 0);
        check("lumdu_stalle", StallE, 1);
        cycle_check();
        check("lumdu_cnt", LoadUseCnt, 0);

        // reset while BUSY, late MduDone ignored, then fresh start
        clear_inputs();
        do_reset();
        MduOpE = 1'b1;
        cycle_check();
        cycle_check();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rstb_busy", MduBusy, 0);
        check("rstb_mscnt", MduStallCnt, 0);
        check("rstb_lucnt", LoadUseCnt, 0);
        check("rstb_flcnt", FlushCnt, 0);
        MduOpE = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        MduDone = 1'b1;
        cycle_check();
        MduDone = 1'b0;
        check("rstb_late_done", MduBusy, 0);
        MduOpE = 1'b1;
        #1;
        check("rstb_restart", MduStart, 1);
        cycle_check();
        clear_inputs();

        // FlushCnt saturation
        do_reset();
        PCSrcE = 1'b1;
        for (int c = 0; c < MAXC + 3; c++) cycle_check();
        check("sat_flcnt", FlushCnt, MAXC);
        clear_inputs();

        // randomized run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
            Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
            RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
            RdW  = AW'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            PCSrcE = (r < 2);
            MduOpE = (r >= 4);
            MduDone = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                clear_inputs();
                do_reset();
            end else begin
                cycle_check();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
